// File: rtl/msg_pkg.sv
// Shared definitions for the FX2 slave-FIFO message path (assembler and writer).
package msg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Frame prefix emitted by the downstream writer ahead of each message.
    localparam logic [15:0] PREFIX = 16'h4444;

    localparam int LEN_W  = 8;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

endpackage

// File: rtl/msg_buf_ram.sv
// 256x16 message buffer: synchronous write, asynchronous (show-ahead) read.
module msg_buf_ram
    import msg_pkg::*;
(
    input  logic              CLK,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // NOTE: the array has no reset; contents are only ever read below the
    // write pointer of a completed message, so stale data is never exposed.
    always_ff @(posedge CLK) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/msg_assembler.sv
// Packs deserializer bytes into 16-bit words, buffers one message and closes it
// on an inter-byte gap or when full, then hands it to the FX2 writer.
module msg_assembler
    import msg_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int unsigned MAX_WORDS  = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        DIN,
    input  logic              DIN_VALID,
    input  logic              RD_REQ,
    input  logic              MSG_SENT,
    output logic [DATA_W-1:0] fifo_q,
    output logic              GOT_FULL_MSG,
    output logic [LEN_W-1:0]  MSG_LEN,
    output logic [15:0]       DROP_CNT,
    output logic [1:0]        state_monitor
);

    localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LEN_W-1:0]  cnt_q, len_q;
    logic [15:0]       gap_q, drop_q;
    logic [7:0]        hi_q;
    logic              half_q, got_q;

    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic              gap_hit;
    logic [LEN_W-1:0]  cnt_inc;

    // NOTE: every signal gets a default before the conditionals so no latch
    // is inferred on the paths that do not assign it.
    always_comb begin
        cnt_inc   = cnt_q + 8'd1;
        gap_hit   = (gap_q == GAP_LAST);
        ram_we    = 1'b0;
        ram_wdata = {hi_q, DIN};
        if (state_q == FILL && half_q) begin
            if (DIN_VALID) begin
                ram_we = 1'b1;
            end else if (gap_hit) begin
                ram_we    = 1'b1;
                ram_wdata = {hi_q, 8'h00};
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            drop_q   <= '0;
            hi_q     <= '0;
            half_q   <= 1'b0;
            got_q    <= 1'b0;
        end else begin
            if (DIN_VALID && (state_q == READY || state_q == DRAIN) && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;

            case (state_q)
                IDLE: begin
                    if (DIN_VALID) begin
                        hi_q    <= DIN;
                        half_q  <= 1'b1;
                        gap_q   <= '0;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (DIN_VALID) begin
                        gap_q <= '0;
                        if (half_q) begin
                            half_q   <= 1'b0;
                            wr_ptr_q <= wr_ptr_q + 8'd1;
                            cnt_q    <= cnt_inc;
                            if (cnt_inc == MAX_LEN) begin
                                len_q   <= cnt_inc;
                                got_q   <= 1'b1;
                                state_q <= READY;
                            end
                        end else begin
                            hi_q   <= DIN;
                            half_q <= 1'b1;
                        end
                    end else if (gap_hit) begin
                        // A pending high byte is flushed as a zero-padded word.
                        half_q  <= 1'b0;
                        got_q   <= 1'b1;
                        state_q <= READY;
                        if (half_q) begin
                            wr_ptr_q <= wr_ptr_q + 8'd1;
                            cnt_q    <= cnt_inc;
                            len_q    <= cnt_inc;
                        end else begin
                            len_q <= cnt_q;
                        end
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                READY, DRAIN: begin
                    if (MSG_SENT) begin
                        got_q    <= 1'b0;
                        len_q    <= '0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end else if (RD_REQ && (state_q == READY || rd_ptr_q < len_q)) begin
                        rd_ptr_q <= rd_ptr_q + 8'd1;
                        state_q  <= DRAIN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    msg_buf_ram u_buf (
        .CLK     (CLK),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (ram_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (fifo_q)
    );

    assign GOT_FULL_MSG  = got_q;
    assign MSG_LEN       = len_q;
    assign DROP_CNT      = drop_q;
    assign state_monitor = state_q;

endmodule

// File: tb/tb_msg_assembler.sv
// Self-checking bench for msg_assembler: vector table for gap-closed messages,
// hand sequences for full close, drops, gap-expiry race and mid-message reset.
module tb_msg_assembler;

    localparam int GAP  = 20;
    localparam int MAXW = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  DIN = 8'h00;
    logic        DIN_VALID = 1'b0;
    logic        RD_REQ = 1'b0;
    logic        MSG_SENT = 1'b0;
    logic [15:0] fifo_q;
    logic        GOT_FULL_MSG;
    logic [7:0]  MSG_LEN;
    logic [15:0] DROP_CNT;
    logic [1:0]  state_monitor;

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  bq[$];

    typedef struct {
        int         n;
        logic [7:0] b [4];
        int         len;
    } vec_t;
    vec_t vecs [4];

    msg_assembler #(.GAP_CYCLES(GAP), .MAX_WORDS(MAXW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .DIN           (DIN),
        .DIN_VALID     (DIN_VALID),
        .RD_REQ        (RD_REQ),
        .MSG_SENT      (MSG_SENT),
        .fifo_q        (fifo_q),
        .GOT_FULL_MSG  (GOT_FULL_MSG),
        .MSG_LEN       (MSG_LEN),
        .DROP_CNT      (DROP_CNT),
        .state_monitor (state_monitor)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_vec(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int len);
        vecs[i].n    = n;
        vecs[i].b[0] = b0;
        vecs[i].b[1] = b1;
        vecs[i].b[2] = b2;
        vecs[i].b[3] = b3;
        vecs[i].len  = len;
    endtask

    // Drive bq back-to-back and push the words the packer must produce.
    task automatic send_msg();
        for (int i = 0; i < bq.size(); i++) begin
            DIN = bq[i];
            DIN_VALID = 1'b1;
            tick();
            if (i % 2 == 1) exp_q.push_back({bq[i-1], bq[i]});
        end
        if (bq.size() % 2 == 1) exp_q.push_back({bq[bq.size()-1], 8'h00});
        DIN_VALID = 1'b0;
        bq.delete();
    endtask

    task automatic stray(input int n);
        for (int i = 0; i < n; i++) begin
            DIN = 8'(8'hE0 + i);
            DIN_VALID = 1'b1;
            tick();
        end
        DIN_VALID = 1'b0;
        exp_drop += n;
    endtask

    // Counts edges after the last accepted byte until the message closes.
    task automatic wait_got(output int n);
        n = 0;
        while (!GOT_FULL_MSG && n < 4 * GAP + 10) begin
            tick();
            n++;
        end
        check("got_after_gap", 32'(GOT_FULL_MSG), 1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: word %0d has no expected value", i);
            end else begin
                check("fifo_q", 32'(fifo_q), 32'(exp_q.pop_front()));
            end
            RD_REQ = 1'b1;
            tick();
            RD_REQ = 1'b0;
            if (i == 0) check("state_drain", 32'(state_monitor), 3);
        end
    endtask

    task automatic finish_msg();
        MSG_SENT = 1'b1;
        tick();
        MSG_SENT = 1'b0;
        check("got_drop_after_sent", 32'(GOT_FULL_MSG), 0);
        check("len_clear_after_sent", 32'(MSG_LEN), 0);
        check("state_idle_after_sent", 32'(state_monitor), 0);
    endtask

    initial begin
        int n;

        set_vec(0, 4, 8'h11, 8'h22, 8'h33, 8'h44, 2);
        set_vec(1, 3, 8'hAA, 8'hBB, 8'hCC, 8'h00, 2);
        set_vec(2, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 1);
        set_vec(3, 2, 8'h01, 8'h02, 8'h00, 8'h00, 1);

        #12;
        check("rst_got", 32'(GOT_FULL_MSG), 0);
        check("rst_len", 32'(MSG_LEN), 0);
        check("rst_drop", 32'(DROP_CNT), 0);
        check("rst_state", 32'(state_monitor), 0);
        RST = 1'b1;
        tick();

        // Gap-closed messages from the vector table.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vecs[v].n; i++) bq.push_back(vecs[v].b[i]);
            send_msg();
            wait_got(n);
            check("gap_latency", 32'(n), GAP);
            check("vec_len", 32'(MSG_LEN), 32'(vecs[v].len));
            check("state_ready", 32'(state_monitor), 2);
            drain(vecs[v].len);
            finish_msg();
        end

        // 510 continuous bytes: closes on word 255 without waiting for the gap.
        for (int i = 0; i < 510; i++) bq.push_back(8'(i * 7 + 3));
        send_msg();
        check("full_got_immediate", 32'(GOT_FULL_MSG), 1);
        check("full_len", 32'(MSG_LEN), 255);
        stray(3);
        check("full_drop", 32'(DROP_CNT), 32'(exp_drop));
        drain(MAXW);
        RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        check("full_still_pending", 32'(GOT_FULL_MSG), 1);
        finish_msg();

        // Pending message plus strays, then a byte coincident with MSG_SENT.
        bq = '{8'h01, 8'h02, 8'h03};
        send_msg();
        wait_got(n);
        check("stray_len", 32'(MSG_LEN), 2);
        stray(5);
        check("stray_drop", 32'(DROP_CNT), 32'(exp_drop));
        DIN = 8'hEE;
        DIN_VALID = 1'b1;
        MSG_SENT = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        MSG_SENT = 1'b0;
        exp_drop++;
        exp_q.delete();
        check("sent_got", 32'(GOT_FULL_MSG), 0);
        check("sent_drop", 32'(DROP_CNT), 32'(exp_drop));
        check("sent_state", 32'(state_monitor), 0);
        bq = '{8'h77, 8'h88};
        send_msg();
        wait_got(n);
        check("restart_len", 32'(MSG_LEN), 1);
        drain(1);
        finish_msg();

        // A byte landing exactly on the gap-expiry cycle keeps the message open.
        DIN = 8'h10;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        repeat (GAP - 1) tick();
        check("pre_expiry_got", 32'(GOT_FULL_MSG), 0);
        DIN = 8'h20;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        check("expiry_no_close", 32'(GOT_FULL_MSG), 0);
        check("expiry_state_fill", 32'(state_monitor), 1);
        exp_q.push_back(16'h1020);
        wait_got(n);
        check("expiry_latency", 32'(n), GAP);
        check("expiry_len", 32'(MSG_LEN), 1);
        drain(1);
        finish_msg();

        // Asynchronous reset in FILL with three words stored.
        bq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        send_msg();
        tick();
        exp_q.delete();
        #2;
        RST = 1'b0;
        #1;
        exp_drop = 0;
        check("midrst_got", 32'(GOT_FULL_MSG), 0);
        check("midrst_len", 32'(MSG_LEN), 0);
        check("midrst_drop", 32'(DROP_CNT), 32'(exp_drop));
        check("midrst_state", 32'(state_monitor), 0);
        RST = 1'b1;
        tick();
        bq = '{8'h9A, 8'hBC};
        send_msg();
        wait_got(n);
        check("post_rst_len", 32'(MSG_LEN), 1);
        drain(1);
        finish_msg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_assembler.md
Name: msg_assembler

Overview:
- Upstream stage of the FX2 slave-FIFO writer.
- Packs a byte stream from the local deserializer into 16-bit words and buffers one message of up to 255 words.
- Closes the message on an inter-byte gap or when the buffer is full, then presents it to the writer.
- Handshake with the writer: GOT_FULL_MSG / MSG_LEN / fifo_q outputs, RD_REQ / MSG_SENT inputs.

Parameters:
- GAP_CYCLES, 1000: idle CLK cycles after the last accepted byte that close a message (range 2..65535).
- MAX_WORDS, 255: word count that force-closes a message (range 1..255; MSG_LEN is 8 bits).

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- DIN  input  8  byte from the deserializer.
- DIN_VALID  input  1  DIN valid this cycle; single-cycle strobe per byte, no backpressure.
- RD_REQ  input  1  writer consumed fifo_q this cycle; advance read pointer.
- MSG_SENT  input  1  one-cycle pulse from the writer: whole message transmitted.
- fifo_q  output  16  show-ahead word at the read pointer.
- GOT_FULL_MSG  output  1  complete message buffered and awaiting transmission.
- MSG_LEN  output  8  message length in 16-bit words; valid while GOT_FULL_MSG=1.
- DROP_CNT  output  16  saturating count of bytes dropped while a message was pending.
- state_monitor  output  2  current state encoding, for debug.

Behaviour:
- Reset: state=IDLE; GOT_FULL_MSG=0, MSG_LEN=0, DROP_CNT=0, state_monitor=0; wr_ptr, rd_ptr, word count, gap timer and half-word flag = 0. Buffered data is discarded.
- fifo_q = mem[rd_ptr], combinational from an 8-bit-address, 16-bit register array. It is valid the cycle GOT_FULL_MSG rises and the cycle after every RD_REQ. This matches the writer sampling fifo_q in the same cycle it pulses RD_REQ.
- States (encoding 0..3): IDLE, FILL, READY, DRAIN.
- Packing order: first byte goes to bits [15:8], second byte to [7:0]. The word is written into mem at wr_ptr on the second byte; wr_ptr and count then increment.
- IDLE:
  - DIN_VALID: latch DIN as the high byte, set half flag, clear gap timer, go FILL.
  - RD_REQ and MSG_SENT are ignored.
- FILL:
  - Each DIN_VALID clears the gap timer; otherwise the timer increments.
  - Gap close: timer == GAP_CYCLES-1 with no DIN_VALID that cycle.
  - Full close: count reaches MAX_WORDS on a word write; close in that same cycle.
  - On close with the half flag set, write {hi, 8'h00}; count+1 in the same cycle.
  - On close: MSG_LEN <= final count, GOT_FULL_MSG <= 1 on the next edge, go READY.
  - DIN_VALID coincident with gap expiry: the byte is accepted, the timer restarts, no close.
- READY:
  - First RD_REQ: rd_ptr+1, go DRAIN.
  - Any DIN_VALID: byte dropped, DROP_CNT+1, saturating at 16'hFFFF. The same drop rule applies in DRAIN.
- DRAIN:
  - RD_REQ: rd_ptr+1 while rd_ptr < MSG_LEN; further RD_REQs are ignored and rd_ptr holds.
- MSG_SENT in READY or DRAIN:
  - Next edge: GOT_FULL_MSG=0, MSG_LEN=0, wr_ptr=rd_ptr=count=0, go IDLE.
  - Requirement: GOT_FULL_MSG must drop within 1 cycle, because the writer re-arms 3 cycles after MSG_SENT.
- MSG_SENT in IDLE or FILL: ignored.
- RD_REQ and MSG_SENT in the same cycle: MSG_SENT wins.
- DIN_VALID in the same cycle as MSG_SENT: the byte is dropped and counted; the new message starts with the next byte.
- MSG_LEN is never 0 while GOT_FULL_MSG=1.
- Reset mid-message: everything clears asynchronously; no partial message is ever presented.

Decomposition:
- Shared package msg_pkg:
  - state encodings IDLE/FILL/READY/DRAIN;
  - PREFIX constant 16'h4444, kept here for the writer too;
  - MSG_LEN width 8.
- One sub-module, msg_buf_ram: 256x16 register array with synchronous write port and asynchronous read port. Kept separate so it can later be swapped for an M9K with a prefetch register.

Test Plan:
- 4 bytes 11,22,33,44 back-to-back, then silence → GOT_FULL_MSG rises GAP_CYCLES cycles after the last byte; MSG_LEN=2; fifo_q=1122, then 3344 after one RD_REQ.
- 3 bytes AA,BB,CC, then gap → MSG_LEN=2; words AABB, CC00.
- 510 bytes continuous → close on word 255 with no gap wait; MSG_LEN=255; byte 511 and later increment DROP_CNT until MSG_SENT.
- Pending message plus 5 stray bytes, then MSG_SENT → DROP_CNT=5; GOT_FULL_MSG=0 one cycle after MSG_SENT; next byte starts a new message with MSG_LEN counted from it.
- DIN_VALID exactly at gap-expiry cycle → no close; message continues and its length includes that byte.
- RST low during FILL with 3 words stored → all outputs 0; next message holds only post-reset data.
